// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON encryption control FSM.
package ascon_pack;

  localparam int unsigned ROUND_W     = 4;
  localparam int unsigned BLK_W       = 4;
  localparam int unsigned NB_ROUNDS_A = 12;
  localparam int unsigned NB_ROUNDS_B = 6;

  // Round-constant indices: p^a runs 0..11, p^b runs the last six (6..11)
  localparam logic [ROUND_W-1:0] ROUND_FIRST_B = ROUND_W'(NB_ROUNDS_A - NB_ROUNDS_B);
  localparam logic [ROUND_W-1:0] ROUND_LAST    = ROUND_W'(NB_ROUNDS_A - 1);
  localparam logic [ROUND_W-1:0] ROUND_ZERO    = '0;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_AD,
    AD,
    WAIT_PT,
    PT,
    FINAL,
    DONE
  } state_t;

  typedef struct packed {
    logic init_state;
    logic en_reg_state;
    logic en_xor_data_begin;
    logic en_xor_key_begin;
    logic en_xor_key_end;
    logic en_xor_lsb_end;
    logic en_cipher;
    logic en_tag;
    logic end_flag;
  } ctrl_t;

  // Moore decode of the datapath controls for a given state and round index
  function automatic ctrl_t decode_ctrl(input state_t st, input logic [ROUND_W-1:0] rnd);
    ctrl_t c;
    c = '0;
    unique case (st)
      INIT: begin
        c.en_reg_state   = 1'b1;
        c.init_state     = (rnd == ROUND_ZERO);
        c.en_xor_key_end = (rnd == ROUND_LAST);
      end
      AD: begin
        c.en_reg_state      = 1'b1;
        c.en_xor_data_begin = (rnd == ROUND_FIRST_B);
        c.en_xor_lsb_end    = (rnd == ROUND_LAST);
      end
      PT: begin
        c.en_reg_state      = 1'b1;
        c.en_xor_data_begin = (rnd == ROUND_FIRST_B);
        c.en_cipher         = (rnd == ROUND_FIRST_B);
      end
      FINAL: begin
        c.en_reg_state      = 1'b1;
        c.en_xor_data_begin = (rnd == ROUND_ZERO);
        c.en_cipher         = (rnd == ROUND_ZERO);
        c.en_xor_key_begin  = (rnd == ROUND_ZERO);
        c.en_xor_key_end    = (rnd == ROUND_LAST);
        c.en_tag            = (rnd == ROUND_LAST);
      end
      DONE:    c.end_flag = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ascon_fsm_if.sv
// Handshake and datapath-control bundle between the ASCON FSM and its user.
interface ascon_fsm_if;
  import ascon_pack::*;

  logic               start_s;
  logic               data_valid_s;
  logic               init_state_s;
  logic               en_reg_state_s;
  logic               en_xor_data_begin_s;
  logic               en_xor_key_begin_s;
  logic               en_xor_key_end_s;
  logic               en_xor_lsb_end_s;
  logic               en_cipher_s;
  logic               en_tag_s;
  logic [ROUND_W-1:0] round_s;
  logic [BLK_W-1:0]   block_cnt_s;
  logic               cipher_valid_s;
  logic               end_s;

  modport master (
    output start_s, data_valid_s,
    input  init_state_s, en_reg_state_s, en_xor_data_begin_s, en_xor_key_begin_s,
    input  en_xor_key_end_s, en_xor_lsb_end_s, en_cipher_s, en_tag_s,
    input  round_s, block_cnt_s, cipher_valid_s, end_s
  );

  modport slave (
    input  start_s, data_valid_s,
    output init_state_s, en_reg_state_s, en_xor_data_begin_s, en_xor_key_begin_s,
    output en_xor_key_end_s, en_xor_lsb_end_s, en_cipher_s, en_tag_s,
    output round_s, block_cnt_s, cipher_valid_s, end_s
  );

endinterface

// File: rtl/ascon_fsm_round_counter.sv
// Permutation round counter: loads 0 (p^a) or 6 (p^b), counts up, flags round 11.
module round_counter
  import ascon_pack::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               load_mid,
  input  logic               en,
  output logic [ROUND_W-1:0] count,
  output logic [ROUND_W-1:0] count_next_c,
  output logic               terminal_c
);

  always_comb begin
    count_next_c = count;
    if (load)
      count_next_c = load_mid ? ROUND_FIRST_B : ROUND_ZERO;
    else if (en)
      count_next_c = count + ROUND_W'(1);
  end

  assign terminal_c = (count == ROUND_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else
      count <= count_next_c;
  end

endmodule

// File: rtl/ascon_fsm.sv
// ASCON-128 encryption sequencer: init, one AD block, NB_PT_BLOCKS plaintext blocks, finalisation.
module ascon_fsm
  import ascon_pack::*;
#(
  parameter int unsigned NB_PT_BLOCKS = 4
) (
  input logic        clock_s,
  input logic        resetb_s,
  ascon_fsm_if.slave bus
);

  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NB_PT_BLOCKS - 1);

  state_t             state;
  state_t             state_next;
  ctrl_t              ctrl_q;
  logic               cipher_valid;
  logic [BLK_W-1:0]   block_cnt;
  logic [ROUND_W-1:0] round;
  logic [ROUND_W-1:0] round_next;
  logic               round_last;
  logic               rc_load;
  logic               rc_load_mid;
  logic               rc_en;
  logic               blk_clr;
  logic               blk_inc;

  round_counter u_round_counter (
    .clk          (clock_s),
    .rst_n        (resetb_s),
    .load         (rc_load),
    .load_mid     (rc_load_mid),
    .en           (rc_en),
    .count        (round),
    .count_next_c (round_next),
    .terminal_c   (round_last)
  );

  // Next state and round-counter steering; WAIT states freeze the counter
  always_comb begin
    state_next  = state;
    rc_load     = 1'b0;
    rc_load_mid = 1'b0;
    rc_en       = 1'b0;
    blk_clr     = 1'b0;
    blk_inc     = 1'b0;
    unique case (state)
      IDLE: begin
        rc_load = 1'b1;
        if (bus.start_s) state_next = INIT;
      end
      INIT: begin
        if (round_last) state_next = WAIT_AD;
        else            rc_en = 1'b1;
      end
      WAIT_AD: begin
        if (bus.data_valid_s) begin
          state_next  = AD;
          rc_load     = 1'b1;
          rc_load_mid = 1'b1;
        end
      end
      AD: begin
        if (round_last) begin
          state_next = WAIT_PT;
          blk_clr    = 1'b1;
        end else begin
          rc_en = 1'b1;
        end
      end
      WAIT_PT: begin
        if (bus.data_valid_s) begin
          rc_load = 1'b1;
          if (block_cnt == LAST_BLK) begin
            state_next = FINAL;
          end else begin
            state_next  = PT;
            rc_load_mid = 1'b1;
          end
        end
      end
      PT: begin
        if (round_last) begin
          state_next = WAIT_PT;
          blk_inc    = 1'b1;
        end else begin
          rc_en = 1'b1;
        end
      end
      FINAL: begin
        if (round_last) begin
          state_next = DONE;
          rc_load    = 1'b1;
        end else begin
          rc_en = 1'b1;
        end
      end
      DONE: begin
        rc_load = 1'b1;
        if (!bus.start_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Controls are decoded from the upcoming state/round so they align with it
  always_ff @(posedge clock_s or negedge resetb_s) begin
    if (!resetb_s) begin
      state        <= IDLE;
      ctrl_q       <= '0;
      cipher_valid <= 1'b0;
      block_cnt    <= '0;
    end else begin
      state        <= state_next;
      ctrl_q       <= decode_ctrl(state_next, round_next);
      cipher_valid <= ctrl_q.en_cipher;
      if (blk_clr)
        block_cnt <= '0;
      else if (blk_inc)
        block_cnt <= block_cnt + BLK_W'(1);
    end
  end

  assign bus.init_state_s        = ctrl_q.init_state;
  assign bus.en_reg_state_s      = ctrl_q.en_reg_state;
  assign bus.en_xor_data_begin_s = ctrl_q.en_xor_data_begin;
  assign bus.en_xor_key_begin_s  = ctrl_q.en_xor_key_begin;
  assign bus.en_xor_key_end_s    = ctrl_q.en_xor_key_end;
  assign bus.en_xor_lsb_end_s    = ctrl_q.en_xor_lsb_end;
  assign bus.en_cipher_s         = ctrl_q.en_cipher;
  assign bus.en_tag_s            = ctrl_q.en_tag;
  assign bus.end_s               = ctrl_q.end_flag;
  assign bus.cipher_valid_s      = cipher_valid;
  assign bus.round_s             = round;
  assign bus.block_cnt_s         = block_cnt;

endmodule

// File: tb/tb_ascon_fsm.sv
// Directed bench for ascon_fsm: timeline checks for 4 and 1 plaintext blocks, reset, stalls, restart.
module tb_ascon_fsm;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ascon_fsm_if bus4 ();
  ascon_fsm_if bus1 ();

  ascon_fsm #(.NB_PT_BLOCKS(4)) dut4 (.clock_s(clk), .resetb_s(rst_n), .bus(bus4));
  ascon_fsm #(.NB_PT_BLOCKS(1)) dut1 (.clock_s(clk), .resetb_s(rst_n), .bus(bus1));

  // bit order: init, en_reg, xor_data_begin, xor_key_begin, xor_key_end, xor_lsb_end, cipher, tag, cipher_valid, end
  function automatic logic [9:0] vec4();
    return {bus4.init_state_s, bus4.en_reg_state_s, bus4.en_xor_data_begin_s, bus4.en_xor_key_begin_s,
            bus4.en_xor_key_end_s, bus4.en_xor_lsb_end_s, bus4.en_cipher_s, bus4.en_tag_s,
            bus4.cipher_valid_s, bus4.end_s};
  endfunction

  function automatic logic [9:0] vec1();
    return {bus1.init_state_s, bus1.en_reg_state_s, bus1.en_xor_data_begin_s, bus1.en_xor_key_begin_s,
            bus1.en_xor_key_end_s, bus1.en_xor_lsb_end_s, bus1.en_cipher_s, bus1.en_tag_s,
            bus1.cipher_valid_s, bus1.end_s};
  endfunction

  // Expected outputs c cycles after start is sampled, data_valid held high; -1 = don't care
  task automatic exp_at(input int c, input int nb, output logic [9:0] v, output int r, output int b);
    int f;
    int off;
    f = 21 + 7 * (nb - 1);
    v = '0;
    r = -1;
    b = -1;
    if (c >= 1 && c <= 12) begin
      v[8] = 1'b1; r = c - 1;
      if (c == 1)  v[9] = 1'b1;
      if (c == 12) v[5] = 1'b1;
    end else if (c >= 14 && c <= 19) begin
      v[8] = 1'b1; r = c - 8;
      if (c == 14) v[7] = 1'b1;
      if (c == 19) v[4] = 1'b1;
    end else if (c >= 20 && c < f) begin
      b   = (c - 20) / 7;
      off = (c - 20) % 7;
      if (off != 0) begin
        v[8] = 1'b1; r = off + 5;
        if (off == 1) begin v[7] = 1'b1; v[3] = 1'b1; end
      end
    end else if (c >= f && c <= f + 11) begin
      v[8] = 1'b1; r = c - f; b = nb - 1;
      if (c == f)      begin v[7] = 1'b1; v[3] = 1'b1; v[6] = 1'b1; end
      if (c == f + 11) begin v[5] = 1'b1; v[2] = 1'b1; end
    end else if (c >= f + 12) begin
      v[0] = 1'b1; r = 0;
    end
    if (c >= 22 && c <= f + 1 && ((c - 22) % 7) == 0) v[1] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus4.start_s = 1'b0; bus4.data_valid_s = 1'b0;
    bus1.start_s = 1'b0; bus1.data_valid_s = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus4.start_s = 1'b0; bus4.data_valid_s = 1'b0;
    bus1.start_s = 1'b0; bus1.data_valid_s = 1'b0;
    repeat (2) tick();
    total++; if (vec4() !== 10'b0) begin bad++; $display("FAIL reset ctrl4 got=%b want=%b", vec4(), 10'b0); end
    total++; if (vec1() !== 10'b0) begin bad++; $display("FAIL reset ctrl1 got=%b want=%b", vec1(), 10'b0); end
    total++; if (bus4.round_s !== 4'd0) begin bad++; $display("FAIL reset round got=%0d want=0", bus4.round_s); end
    total++; if (bus4.block_cnt_s !== 4'd0) begin bad++; $display("FAIL reset block_cnt got=%0d want=0", bus4.block_cnt_s); end
    rst_n = 1'b1;
    tick();
    total++; if (vec4() !== 10'b0) begin bad++; $display("FAIL idle ctrl4 got=%b want=%b", vec4(), 10'b0); end
  endtask

  // Full NB=4 run with start held high throughout, so DONE must persist
  task automatic test_full_run();
    logic [9:0] ev;
    int er, eb;
    int n_cv, n_tag;
    n_cv = 0; n_tag = 0;
    apply_reset();
    bus4.start_s = 1'b1; bus4.data_valid_s = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      exp_at(c, 4, ev, er, eb);
      total++; if (vec4() !== ev) begin bad++; $display("FAIL full4 ctrl c=%0d got=%b want=%b", c, vec4(), ev); end
      if (er >= 0) begin
        total++; if (bus4.round_s !== 4'(er)) begin bad++; $display("FAIL full4 round c=%0d got=%0d want=%0d", c, bus4.round_s, er); end
      end
      if (eb >= 0) begin
        total++; if (bus4.block_cnt_s !== 4'(eb)) begin bad++; $display("FAIL full4 block_cnt c=%0d got=%0d want=%0d", c, bus4.block_cnt_s, eb); end
      end
      if (bus4.cipher_valid_s === 1'b1) n_cv++;
      if (bus4.en_tag_s === 1'b1) n_tag++;
    end
    total++; if (n_cv !== 4) begin bad++; $display("FAIL full4 cipher_valid pulses got=%0d want=4", n_cv); end
    total++; if (n_tag !== 1) begin bad++; $display("FAIL full4 tag pulses got=%0d want=1", n_tag); end
  endtask

  // Continues from DONE: drop start to leave, raise it to begin again
  task automatic test_done_restart();
    bus4.start_s = 1'b0;
    tick();
    total++; if (vec4() !== 10'b0) begin bad++; $display("FAIL done->idle ctrl got=%b want=%b", vec4(), 10'b0); end
    total++; if (bus4.round_s !== 4'd0) begin bad++; $display("FAIL done->idle round got=%0d want=0", bus4.round_s); end
    bus4.start_s = 1'b1;
    tick();
    total++; if (vec4() !== 10'b1100000000) begin bad++; $display("FAIL restart ctrl got=%b want=%b", vec4(), 10'b1100000000); end
    total++; if (bus4.round_s !== 4'd0) begin bad++; $display("FAIL restart round got=%0d want=0", bus4.round_s); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] ev;
    int er, eb;
    apply_reset();
    bus4.start_s = 1'b1; bus4.data_valid_s = 1'b1;
    for (int c = 1; c <= 16; c++) tick();
    exp_at(16, 4, ev, er, eb);
    total++; if (bus4.round_s !== 4'(er)) begin bad++; $display("FAIL midrst pre round got=%0d want=%0d", bus4.round_s, er); end
    total++; if (vec4() !== ev) begin bad++; $display("FAIL midrst pre ctrl got=%b want=%b", vec4(), ev); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (vec4() !== 10'b0) begin bad++; $display("FAIL midrst async ctrl got=%b want=%b", vec4(), 10'b0); end
    total++; if (bus4.round_s !== 4'd0) begin bad++; $display("FAIL midrst async round got=%0d want=0", bus4.round_s); end
    total++; if (bus4.block_cnt_s !== 4'd0) begin bad++; $display("FAIL midrst async block_cnt got=%0d want=0", bus4.block_cnt_s); end
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (vec4() !== 10'b1100000000) begin bad++; $display("FAIL midrst restart ctrl got=%b want=%b", vec4(), 10'b1100000000); end
    total++; if (bus4.round_s !== 4'd0) begin bad++; $display("FAIL midrst restart round got=%0d want=0", bus4.round_s); end
  endtask

  // data_valid low for 10 cycles after INIT; start dropped mid-wait must be ignored
  task automatic test_wait_ad();
    logic [9:0] ev;
    int er, eb;
    logic [3:0] r_hold;
    apply_reset();
    bus4.start_s = 1'b1; bus4.data_valid_s = 1'b0;
    for (int c = 1; c <= 12; c++) tick();
    total++; if (bus4.en_xor_key_end_s !== 1'b1) begin bad++; $display("FAIL wait init last key_end got=%b want=1", bus4.en_xor_key_end_s); end
    r_hold = 4'd0;
    for (int c = 13; c <= 22; c++) begin
      tick();
      if (c == 13) r_hold = bus4.round_s;
      if (c == 15) bus4.start_s = 1'b0;
      total++; if (vec4() !== 10'b0) begin bad++; $display("FAIL wait_ad ctrl c=%0d got=%b want=%b", c, vec4(), 10'b0); end
      total++; if (bus4.round_s !== r_hold) begin bad++; $display("FAIL wait_ad round c=%0d got=%0d want=%0d", c, bus4.round_s, r_hold); end
    end
    bus4.data_valid_s = 1'b1;
    for (int c = 23; c <= 45; c++) begin
      tick();
      exp_at(c - 9, 4, ev, er, eb);
      total++; if (vec4() !== ev) begin bad++; $display("FAIL wait_ad resume ctrl c=%0d got=%b want=%b", c, vec4(), ev); end
      if (er >= 0) begin
        total++; if (bus4.round_s !== 4'(er)) begin bad++; $display("FAIL wait_ad resume round c=%0d got=%0d want=%0d", c, bus4.round_s, er); end
      end
    end
  endtask

  task automatic test_nb1();
    logic [9:0] ev;
    int er, eb;
    int n_cv;
    n_cv = 0;
    apply_reset();
    bus1.start_s = 1'b1; bus1.data_valid_s = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      exp_at(c, 1, ev, er, eb);
      total++; if (vec1() !== ev) begin bad++; $display("FAIL nb1 ctrl c=%0d got=%b want=%b", c, vec1(), ev); end
      if (er >= 0) begin
        total++; if (bus1.round_s !== 4'(er)) begin bad++; $display("FAIL nb1 round c=%0d got=%0d want=%0d", c, bus1.round_s, er); end
      end
      if (bus1.cipher_valid_s === 1'b1) n_cv++;
    end
    total++; if (n_cv !== 1) begin bad++; $display("FAIL nb1 cipher_valid pulses got=%0d want=1", n_cv); end
  endtask

  initial begin
    bus4.start_s = 1'b0; bus4.data_valid_s = 1'b0;
    bus1.start_s = 1'b0; bus1.data_valid_s = 1'b0;
    test_reset();
    test_full_run();
    test_done_restart();
    test_reset_mid();
    test_wait_ad();
    test_nb1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascon_fsm.md
ASCON_FSM -- requirements
Module: ascon_fsm

Interface
REQ-001 Parameter: NB_PT_BLOCKS, 4, number of 64-bit plaintext blocks after the single associated-data block (range 1..15).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clock_s  in  1  system clock; all state updates on the rising edge.
REQ-004 resetb_s  in  1  asynchronous active-low reset.
REQ-005 start_s  in  1  level request to begin one encryption.
REQ-006 data_valid_s  in  1  data_s word (AD or plaintext) is valid.
REQ-007 init_state_s  out  1  permutation input mux selects IV||K||N instead of the state register.
REQ-008 en_reg_state_s  out  1  state register captures one permutation round.
REQ-009 en_xor_data_begin_s  out  1  XOR data_s into x0 before the round.
REQ-010 en_xor_key_begin_s  out  1  XOR key into x1||x2 before the round.
REQ-011 en_xor_key_end_s  out  1  XOR key into x3||x4 after the round.
REQ-012 en_xor_lsb_end_s  out  1  XOR 1 into the x4 LSB after the round (domain separation).
REQ-013 en_cipher_s  out  1  cipher register captures x0 xor data_s.
REQ-014 en_tag_s  out  1  tag register captures the final x3||x4.
REQ-015 round_s  out  4  round-constant index 0..11.
REQ-016 block_cnt_s  out  4  index of the current plaintext block.
REQ-017 cipher_valid_s  out  1  one-cycle pulse: cipher register holds a new block.
REQ-018 end_s  out  1  tag is valid and the encryption is complete.

Function
REQ-019 States: IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE; one permutation round per cycle.
REQ-020 IDLE: all outputs 0; start_s=1 -> INIT with round 0.
REQ-021 INIT: 12 cycles, round_s 0..11, en_reg_state_s=1 throughout.
REQ-022 INIT: init_state_s=1 only at round 0; en_xor_key_end_s=1 only at round 11; after round 11 -> WAIT_AD.
REQ-023 WAIT_AD/WAIT_PT: en_reg_state_s=0; one cycle minimum; with data_valid_s=1 -> AD/PT (or FINAL) starting at round 6; otherwise hold.
REQ-024 AD: rounds 6..11, en_reg_state_s=1.
REQ-025 AD: en_xor_data_begin_s=1 at round 6; en_xor_lsb_end_s=1 at round 11; then -> WAIT_PT with block_cnt_s=0.
REQ-026 PT (non-last block, block_cnt_s<NB_PT_BLOCKS-1): rounds 6..11, en_reg_state_s=1.
REQ-027 PT: en_xor_data_begin_s=1 and en_cipher_s=1 at round 6; at round 11 block_cnt_s increments, then -> WAIT_PT.
REQ-028 Last block (block_cnt_s=NB_PT_BLOCKS-1): WAIT_PT exits to FINAL at round 0.
REQ-029 FINAL: rounds 0..11, en_reg_state_s=1.
REQ-030 FINAL: en_xor_data_begin_s, en_cipher_s and en_xor_key_begin_s =1 at round 0; en_xor_key_end_s and en_tag_s =1 at round 11; then -> DONE.
REQ-031 cipher_valid_s registered: high exactly the cycle after each en_cipher_s cycle.
REQ-032 DONE: end_s=1, all enables 0; leaves to IDLE only when start_s=0.
REQ-033 In DONE, end_s=1 persists while start_s stays high; no restart until start_s drops.
REQ-034 data_valid_s is ignored outside WAIT_AD/WAIT_PT.
REQ-035 start_s is ignored outside IDLE and DONE.
REQ-036 round_s=0 in IDLE and DONE.
REQ-037 Control outputs are Moore (decoded from state and round counter); no combinational path from inputs.

Reset
REQ-038 resetb_s=0 at any time, including mid-permutation: state IDLE, round_s=0, block_cnt_s=0, every output 0, asynchronously.
REQ-039 After release, the first start_s high sampled begins a fresh encryption.

Structure
REQ-040 The state enum typedef shall live in ascon_pack.
REQ-041 Round-count constants (12, 6) shall live in ascon_pack.
REQ-042 One sub-module round_counter: 4-bit, load value 0 or 6, enable, terminal flag at 11.
REQ-043 block_cnt_s shall be a local register inside ascon_fsm.

Verification
REQ-044 Reset, then start_s=1 at edge k with data_valid_s held 1, NB_PT_BLOCKS=4 -> INIT k+1..k+12, AD k+14..k+19, PT blocks at k+21, k+28, k+35, FINAL k+42..k+53, end_s=1 from k+54.
REQ-045 Same run -> exactly 4 cipher_valid_s pulses at k+22, k+29, k+36, k+43; en_tag_s exactly once, at k+53.
REQ-046 data_valid_s=0 for 10 cycles after INIT -> WAIT_AD holds with en_reg_state_s=0 and round_s stable; resumes on data_valid_s=1.
REQ-047 resetb_s=0 during AD round 8 -> all outputs 0 immediately; next start_s restarts at INIT round 0.
REQ-048 start_s held 1 through DONE -> end_s stays 1; start_s=0 then 1 -> new INIT sequence.
REQ-049 NB_PT_BLOCKS=1 -> WAIT_PT goes straight to FINAL; a single cipher_valid_s pulse.
